pipelined_mac: RTL and testbench

PIPELINED_MAC -- requirements
Module: pipelined_mac

---
 rtl/pipelined_mac.sv | 101 ++++++++++
 tb/tb_pipelined_mac.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_mac.sv
// Two-stage multiply-accumulate: stage 1 registers the product, stage 2 accumulates
// with per-beat signed/unsigned mode, optional saturation and a sticky overflow flag.
module pipelined_mac #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 2*WIDTH+8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 tc,
    input  logic                 acc_clr,
    input  logic                 sat_en,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] out,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] count
);
    localparam int PW = 2*WIDTH;

    logic [PW-1:0]        w_a_ext, w_b_ext, w_prod;
    logic [PW-1:0]        r_prod;
    logic                 r_tc, r_clr, r_sat;
    logic [1:0]           r_vld_pipe;
    logic [ACC_WIDTH-1:0] r_out;
    logic                 r_ovf;
    logic [CNT_WIDTH-1:0] r_cnt;

    // Operands widened to the product width first, so the low 2*WIDTH bits are exact in both modes
    always_comb begin
        if (tc) begin
            w_a_ext = {{WIDTH{a[WIDTH-1]}}, a};
            w_b_ext = {{WIDTH{b[WIDTH-1]}}, b};
        end else begin
            w_a_ext = {{WIDTH{1'b0}}, a};
            w_b_ext = {{WIDTH{1'b0}}, b};
        end
        w_prod = w_a_ext * w_b_ext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], in_valid};
            if (in_valid) begin
                r_prod <= w_prod;
                r_tc   <= tc;
                r_clr  <= acc_clr;
                r_sat  <= sat_en;
            end
        end
    end

    logic signed [PW-1:0]        w_prod_s;
    logic signed [ACC_WIDTH-1:0] w_ext_s;
    logic [ACC_WIDTH-1:0]        w_ext, w_sat_val, w_acc;
    logic [ACC_WIDTH:0]          w_sum_s, w_sum_u;
    logic                        w_ovf;

    always_comb begin
        w_prod_s = r_prod;
        w_ext_s  = w_prod_s;
        w_ext    = r_tc ? ACC_WIDTH'(w_ext_s) : ACC_WIDTH'(r_prod);
        w_sum_s  = {r_out[ACC_WIDTH-1], r_out} + {w_ext[ACC_WIDTH-1], w_ext};
        w_sum_u  = {1'b0, r_out} + {1'b0, w_ext};
        w_ovf    = r_tc ? (w_sum_s[ACC_WIDTH] ^ w_sum_s[ACC_WIDTH-1]) : w_sum_u[ACC_WIDTH];
        // Clamp direction comes from the true (ACC_WIDTH+1)-bit sign of the signed sum
        if (r_tc)
            w_sat_val = w_sum_s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                           : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        else
            w_sat_val = '1;
        w_acc = (w_ovf && r_sat) ? w_sat_val : w_sum_s[ACC_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
            r_ovf <= 1'b0;
            r_cnt <= '0;
        end else if (r_vld_pipe[0]) begin
            if (r_clr) begin
                r_out <= w_ext;
                r_ovf <= 1'b0;
                r_cnt <= CNT_WIDTH'(1);
            end else begin
                r_out <= w_acc;
                r_ovf <= r_ovf | w_ovf;
                r_cnt <= (r_cnt == '1) ? r_cnt : r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign out_valid = r_vld_pipe[1];
    assign out       = r_out;
    assign overflow  = r_ovf;
    assign count     = r_cnt;
endmodule

// File: tb/tb_pipelined_mac.sv
// Self-checking bench for pipelined_mac (WIDTH=8, ACC_WIDTH=16, CNT_WIDTH=4) against an
// arithmetic reference model of the accumulator and its two-cycle visibility.
module tb_pipelined_mac;
    localparam int    AW   = 16;
    localparam int    CW   = 4;
    localparam longint MASK = 65535;
    localparam longint MAXS = 32767;
    localparam longint MINS = -32768;
    localparam longint CMAX = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    a = '0, b = '0;
    logic          tc = 1'b0, acc_clr = 1'b0, sat_en = 1'b0;
    logic          out_valid;
    logic [AW-1:0] out;
    logic          overflow;
    logic [CW-1:0] count;

    int checks = 0;
    int failures = 0;

    pipelined_mac #(.WIDTH(8), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .tc(tc),
        .acc_clr(acc_clr), .sat_en(sat_en), .out_valid(out_valid), .out(out),
        .overflow(overflow), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit         r;
        bit         v;
        logic [7:0] a;
        logic [7:0] b;
        bit         tc;
        bit         clr;
        bit         sat;
    } row_t;

    // Model: p_* is the state after all beats sampled so far; c_* is what the DUT shows now
    bit            p_v, c_v;
    bit            p_ovf, c_ovf;
    logic [CW-1:0] p_cnt, c_cnt;
    logic [AW-1:0] p_o, c_o;

    logic [AW-1:0] obs_o [16];
    logic [CW-1:0] obs_c [16];
    bit            obs_f [16];
    bit            obs_v [16];

    function automatic row_t mk(bit v, logic [7:0] ma, logic [7:0] mb, bit mtc, bit mclr, bit msat, bit mr = 1'b0);
        row_t t;
        t.r = mr; t.v = v; t.a = ma; t.b = mb; t.tc = mtc; t.clr = mclr; t.sat = msat;
        return t;
    endfunction

    task automatic model_beat(input row_t t);
        longint p, cur, s;
        bit     of;
        p = t.tc ? longint'($signed(t.a)) * longint'($signed(t.b)) : longint'(t.a) * longint'(t.b);
        if (t.clr) begin
            p_o = AW'(p & MASK); p_ovf = 1'b0; p_cnt = CW'(1);
        end else begin
            cur = longint'(p_o);
            if (t.tc && cur > MAXS) cur = cur - (MASK + 1);
            s = cur + p;
            if (t.tc) begin
                of = (s > MAXS) || (s < MINS);
                if (of && t.sat) s = (s > MAXS) ? MAXS : MINS;
            end else begin
                of = s > MASK;
                if (of && t.sat) s = MASK;
            end
            p_o   = AW'(s & MASK);
            p_ovf = p_ovf | of;
            p_cnt = (longint'(p_cnt) == CMAX) ? p_cnt : p_cnt + CW'(1);
        end
    endtask

    task automatic step(input row_t t);
        @(negedge clk);
        rst = t.r; in_valid = t.v; a = t.a; b = t.b; tc = t.tc; acc_clr = t.clr; sat_en = t.sat;
        @(posedge clk);
        #1;
        if (t.r) begin
            c_v = 0; c_ovf = 0; c_cnt = '0; c_o = '0;
            p_v = 0; p_ovf = 0; p_cnt = '0; p_o = '0;
        end else begin
            c_v = p_v; c_ovf = p_ovf; c_cnt = p_cnt; c_o = p_o;
            p_v = t.v;
            if (t.v) model_beat(t);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(mk(1'b1, 8'd7, 8'd9, 1'b0, 1'b0, 1'b0, 1'b1));
            checks++;
            if ({out_valid, overflow, count, out} !== {1'b0, 1'b0, 4'd0, 16'd0}) begin
                failures++;
                $display("FAIL reset[%0d] got v=%0b ovf=%0b cnt=%0d out=%0d want all zero", i, out_valid, overflow, count, out);
            end
        end
    endtask

    task automatic test_basic();
        row_t rows [3];
        rows[0] = mk(1, 8'd3, 8'd5, 1, 1, 0);
        rows[1] = mk(1, 8'hFD, 8'd3, 1, 0, 0);
        rows[2] = mk(0, 8'd0, 8'd0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(rows[i]);
            obs_o[i] = out; obs_c[i] = count; obs_f[i] = overflow; obs_v[i] = out_valid;
            checks++;
            if ({out_valid, overflow, count, out} !== {c_v, c_ovf, c_cnt, c_o}) begin
                failures++;
                $display("FAIL basic[%0d] got v=%0b ovf=%0b cnt=%0d out=%0d want v=%0b ovf=%0b cnt=%0d out=%0d",
                         i, out_valid, overflow, count, out, c_v, c_ovf, c_cnt, c_o);
            end
        end
        checks++;
        if ({obs_v[0], obs_v[1], obs_o[1], obs_c[1], obs_v[2], obs_o[2], obs_c[2]} !== {1'b0, 1'b1, 16'd15, 4'd1, 1'b1, 16'd6, 4'd2}) begin
            failures++;
            $display("FAIL basic_vec got out=%0d,%0d cnt=%0d,%0d want 15,6 cnt 1,2", obs_o[1], obs_o[2], obs_c[1], obs_c[2]);
        end
    endtask

    task automatic test_saturate();
        row_t rows [8];
        rows[0] = mk(1, 8'd127, 8'd127, 1, 1, 1);
        rows[1] = mk(1, 8'd127, 8'd127, 1, 0, 1);
        rows[2] = mk(1, 8'd127, 8'd127, 1, 0, 1);
        rows[3] = mk(1, 8'd127, 8'd127, 1, 1, 0);
        rows[4] = mk(1, 8'd127, 8'd127, 1, 0, 0);
        rows[5] = mk(1, 8'd127, 8'd127, 1, 0, 0);
        rows[6] = mk(0, 8'd0, 8'd0, 0, 0, 0);
        rows[7] = mk(0, 8'd0, 8'd0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(rows[i]);
            obs_o[i] = out; obs_c[i] = count; obs_f[i] = overflow; obs_v[i] = out_valid;
            checks++;
            if ({out_valid, overflow, count, out} !== {c_v, c_ovf, c_cnt, c_o}) begin
                failures++;
                $display("FAIL saturate[%0d] got v=%0b ovf=%0b cnt=%0d out=%0d want v=%0b ovf=%0b cnt=%0d out=%0d",
                         i, out_valid, overflow, count, out, c_v, c_ovf, c_cnt, c_o);
            end
        end
        checks++;
        if ({obs_o[1], obs_o[2], obs_o[3], obs_f[3], obs_f[4], obs_o[6], obs_f[6]} !== {16'd16129, 16'd32258, 16'd32767, 1'b1, 1'b0, 16'hBD03, 1'b1}) begin
            failures++;
            $display("FAIL saturate_vec got %0d %0d %0d ovf=%0b wrap=%0d ovf=%0b want 16129 32258 32767 1 -17149 1",
                     obs_o[1], obs_o[2], obs_o[3], obs_f[3], $signed(obs_o[6]), obs_f[6]);
        end
    endtask

    task automatic test_sign_edges();
        row_t rows [8];
        rows[0] = mk(1, 8'h80, 8'h01, 1, 1, 0);
        rows[1] = mk(1, 8'hFB, 8'hFE, 1, 0, 0);
        rows[2] = mk(1, 8'h00, 8'hFF, 1, 0, 0);
        rows[3] = mk(1, 8'h80, 8'h80, 1, 0, 0);
        rows[4] = mk(0, 8'h00, 8'h00, 0, 0, 0);
        rows[5] = mk(1, 8'hFF, 8'hFF, 0, 1, 0);
        rows[6] = mk(1, 8'hFF, 8'hFF, 1, 0, 0);
        rows[7] = mk(0, 8'h00, 8'h00, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(rows[i]);
            obs_o[i] = out; obs_c[i] = count; obs_f[i] = overflow; obs_v[i] = out_valid;
            checks++;
            if ({out_valid, overflow, count, out} !== {c_v, c_ovf, c_cnt, c_o}) begin
                failures++;
                $display("FAIL sign[%0d] got v=%0b ovf=%0b cnt=%0d out=%0d want v=%0b ovf=%0b cnt=%0d out=%0d",
                         i, out_valid, overflow, count, out, c_v, c_ovf, c_cnt, c_o);
            end
        end
        checks++;
        if ({obs_o[1], obs_o[2], obs_o[3], obs_o[4], obs_o[6], obs_o[7], obs_f[7]} !== {16'hFF80, 16'hFF8A, 16'hFF8A, 16'd16266, 16'd65025, 16'd65026, 1'b0}) begin
            failures++;
            $display("FAIL sign_vec got %0d %0d %0d %0d %0d %0d want -128 -118 -118 16266 65025 65026",
                     $signed(obs_o[1]), $signed(obs_o[2]), $signed(obs_o[3]), obs_o[4], obs_o[6], obs_o[7]);
        end
    endtask

    task automatic test_reset_mid();
        row_t rows [6];
        rows[0] = mk(1, 8'd3, 8'd3, 1, 1, 0);
        rows[1] = mk(1, 8'd1, 8'd1, 1, 0, 0);
        rows[2] = mk(1, 8'd5, 8'd5, 1, 0, 0, 1);
        rows[3] = mk(1, 8'd2, 8'd2, 1, 0, 0);
        rows[4] = mk(0, 8'd0, 8'd0, 0, 0, 0);
        rows[5] = mk(0, 8'd0, 8'd0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(rows[i]);
            obs_o[i] = out; obs_c[i] = count; obs_f[i] = overflow; obs_v[i] = out_valid;
            checks++;
            if ({out_valid, overflow, count, out} !== {c_v, c_ovf, c_cnt, c_o}) begin
                failures++;
                $display("FAIL reset_mid[%0d] got v=%0b ovf=%0b cnt=%0d out=%0d want v=%0b ovf=%0b cnt=%0d out=%0d",
                         i, out_valid, overflow, count, out, c_v, c_ovf, c_cnt, c_o);
            end
        end
        checks++;
        if ({obs_v[1], obs_o[1], obs_v[2], obs_o[2], obs_c[2], obs_v[3], obs_v[4], obs_o[4], obs_c[4], obs_v[5]}
            !== {1'b1, 16'd9, 1'b0, 16'd0, 4'd0, 1'b0, 1'b1, 16'd4, 4'd1, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_vec got v=%0b%0b%0b%0b%0b out=%0d cnt=%0d want v=10010 out=4 cnt=1",
                     obs_v[1], obs_v[2], obs_v[3], obs_v[4], obs_v[5], obs_o[4], obs_c[4]);
        end
    endtask

    task automatic test_gaps_clear();
        row_t rows [10];
        rows[0] = mk(1, 8'd1, 8'd2, 1, 1, 0);
        rows[1] = mk(0, 8'd9, 8'd9, 1, 1, 0);
        rows[2] = mk(1, 8'd3, 8'd1, 1, 0, 0);
        rows[3] = mk(0, 8'd0, 8'd0, 0, 0, 0);
        rows[4] = mk(1, 8'd127, 8'd127, 1, 0, 0);
        rows[5] = mk(1, 8'd127, 8'd127, 1, 0, 0);
        rows[6] = mk(1, 8'd127, 8'd127, 1, 0, 0);
        rows[7] = mk(1, 8'd7, 8'd7, 1, 1, 0);
        rows[8] = mk(0, 8'd0, 8'd0, 0, 0, 0);
        rows[9] = mk(0, 8'd0, 8'd0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(rows[i]);
            obs_o[i] = out; obs_c[i] = count; obs_f[i] = overflow; obs_v[i] = out_valid;
            checks++;
            if ({out_valid, overflow, count, out} !== {c_v, c_ovf, c_cnt, c_o}) begin
                failures++;
                $display("FAIL gaps[%0d] got v=%0b ovf=%0b cnt=%0d out=%0d want v=%0b ovf=%0b cnt=%0d out=%0d",
                         i, out_valid, overflow, count, out, c_v, c_ovf, c_cnt, c_o);
            end
        end
        checks++;
        if ({obs_v[2], obs_o[2], obs_o[3], obs_f[7], obs_o[8], obs_f[8], obs_c[8]} !== {1'b0, 16'd2, 16'd5, 1'b1, 16'd49, 1'b0, 4'd1}) begin
            failures++;
            $display("FAIL gaps_vec got hold=%0d sum=%0d ovf=%0b clr_out=%0d ovf=%0b cnt=%0d want 2 5 1 49 0 1",
                     obs_o[2], obs_o[3], obs_f[7], obs_o[8], obs_f[8], obs_c[8]);
        end
    endtask

    task automatic test_count_sat();
        step(mk(1, 8'd1, 8'd1, 0, 1, 0));
        for (int i = 0; i < 20; i++) step(mk(1, 8'd0, 8'd0, 0, 0, 0));
        step(mk(0, 8'd0, 8'd0, 0, 0, 0));
        step(mk(0, 8'd0, 8'd0, 0, 0, 0));
        checks++;
        if ({count, out, out_valid} !== {4'd15, 16'd1, 1'b0} || count !== c_cnt) begin
            failures++;
            $display("FAIL count_sat got cnt=%0d out=%0d v=%0b want cnt=15 out=1 v=0", count, out, out_valid);
        end
    endtask

    task automatic test_random();
        row_t t;
        for (int i = 0; i < 400; i++) begin
            t = mk($urandom_range(0, 99) < 75, 8'($urandom), 8'($urandom), 1'($urandom),
                   $urandom_range(0, 99) < 15, 1'($urandom), $urandom_range(0, 99) < 2);
            step(t);
            checks++;
            if ({out_valid, overflow, count, out} !== {c_v, c_ovf, c_cnt, c_o}) begin
                failures++;
                $display("FAIL random[%0d] got v=%0b ovf=%0b cnt=%0d out=%0d want v=%0b ovf=%0b cnt=%0d out=%0d",
                         i, out_valid, overflow, count, out, c_v, c_ovf, c_cnt, c_o);
            end
        end
    endtask

    initial begin
        p_v = 0; p_ovf = 0; p_cnt = '0; p_o = '0;
        c_v = 0; c_ovf = 0; c_cnt = '0; c_o = '0;
        test_reset();
        test_basic();
        test_saturate();
        test_sign_edges();
        test_reset_mid();
        test_gaps_clear();
        test_count_sat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
